// File: rtl/note_sequencer.sv
// Melody playback: walks a 32-beat ROM at a fixed tempo and emits tone dividers for the speaker.
// Define NOTE_SEQ_LOOP_EN to loop the song forever instead of stopping and pulsing done.
module note_sequencer #(
   parameter int unsigned BEAT_CYCLES = 25_000_000,
   parameter int unsigned GAP_CYCLES  = 2_500_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        play,
   input  logic        pause,
   input  logic        stop,
   output logic [21:0] note_div,
   output logic [4:0]  beat_idx,
   output logic        playing,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

   localparam logic [25:0] BEAT_LAST = 26'(BEAT_CYCLES - 1);
   localparam logic [25:0] TONE_END  = 26'(BEAT_CYCLES - GAP_CYCLES);

   state_t      st, st_nxt;
   logic [4:0]  idx_nxt;
   logic [25:0] beat_cnt, cnt_nxt;
   logic        done_nxt;

   // Melody ROM; the upper 16 beats repeat the lower 16, so only 4 index bits matter.
   function automatic logic [3:0] rom_code(input logic [3:0] i);
      case (i)
         4'd0, 4'd1, 4'd14:         rom_code = 4'd1;
         4'd2, 4'd3, 4'd6:          rom_code = 4'd5;
         4'd4, 4'd5:                rom_code = 4'd6;
         4'd8, 4'd9:                rom_code = 4'd4;
         4'd10, 4'd11:              rom_code = 4'd3;
         4'd12, 4'd13:              rom_code = 4'd2;
         default:                   rom_code = 4'd0;
      endcase
   endfunction

   function automatic logic [21:0] div_of(input logic [3:0] code);
      case (code)
         4'd1:    div_of = 22'd381679;
         4'd2:    div_of = 22'd340136;
         4'd3:    div_of = 22'd303030;
         4'd4:    div_of = 22'd286532;
         4'd5:    div_of = 22'd255102;
         4'd6:    div_of = 22'd227272;
         4'd7:    div_of = 22'd202429;
         4'd8:    div_of = 22'd190839;
         4'd9:    div_of = 22'd170068;
         4'd10:   div_of = 22'd151515;
         4'd11:   div_of = 22'd143266;
         4'd12:   div_of = 22'd127551;
         4'd13:   div_of = 22'd113636;
         4'd14:   div_of = 22'd101214;
         4'd15:   div_of = 22'd95419;
         default: div_of = '0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st       <= IDLE;
         beat_idx <= '0;
         beat_cnt <= '0;
         done     <= 1'b0;
      end else begin
         st       <= st_nxt;
         beat_idx <= idx_nxt;
         beat_cnt <= cnt_nxt;
         done     <= done_nxt;
      end
   end

   always_comb begin
      st_nxt   = st;
      idx_nxt  = beat_idx;
      cnt_nxt  = beat_cnt;
      done_nxt = 1'b0;
      if (stop) begin
         st_nxt  = IDLE;
         idx_nxt = '0;
         cnt_nxt = '0;
      end else begin
         case (st)
            IDLE: begin
               if (play) begin
                  st_nxt  = PLAY;
                  idx_nxt = '0;
                  cnt_nxt = '0;
               end
            end
            PLAY: begin
               if (pause) begin
                  st_nxt = PAUSE;
               end else if (beat_cnt == BEAT_LAST) begin
                  cnt_nxt = '0;
                  idx_nxt = beat_idx + 5'd1;
                  if (beat_idx == 5'd31) begin
`ifdef NOTE_SEQ_LOOP_EN
                     idx_nxt = '0;
`else
                     st_nxt   = IDLE;
                     idx_nxt  = '0;
                     done_nxt = 1'b1;
`endif
                  end
               end else begin
                  cnt_nxt = beat_cnt + 26'd1;
               end
            end
            PAUSE: begin
               if (play) st_nxt = PLAY;
            end
            default: st_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      playing  = (st == PLAY);
      note_div = '0;
      if (st == PLAY && beat_cnt < TONE_END) note_div = div_of(rom_code(beat_idx[3:0]));
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus random button pulses vs a song-position model.
module tb_note_sequencer;
   localparam int BEAT = 10;
   localparam int GAP  = 2;

   logic        clk = 1'b0;
   logic        rst, play, pause, stop;
   logic [21:0] note_div;
   logic [4:0]  beat_idx;
   logic        playing, done;

   note_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
      .note_div(note_div), .beat_idx(beat_idx), .playing(playing), .done(done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int rom_tab[16] = '{1,1,5,5,6,6,5,0,4,4,3,3,2,2,1,0};
   int div_tab[16] = '{0,381679,340136,303030,286532,255102,227272,202429,
                       190839,170068,151515,143266,127551,113636,101214,95419};

   // Model: mode 0=idle 1=play 2=pause; pos = cycles elapsed within the song.
   int mode = 0;
   int pos  = 0;
   bit exp_done = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_div();
      if (mode != 1 || (pos % BEAT) >= BEAT - GAP) return 0;
      return div_tab[rom_tab[(pos / BEAT) % 16]];
   endfunction

   task automatic check_all(input string tag);
      check_eq({tag, ".idx"},  32'(beat_idx), 32'(pos / BEAT));
      check_eq({tag, ".div"},  32'(note_div), 32'(exp_div()));
      check_eq({tag, ".play"}, 32'(playing),  32'(mode == 1));
      check_eq({tag, ".done"}, 32'(done),     32'(exp_done));
   endtask

   task automatic step(input bit p, input bit pa, input bit s, input string tag);
      play = p; pause = pa; stop = s;
      @(posedge clk);
      exp_done = 0;
      if (s) begin
         mode = 0; pos = 0;
      end else if (mode == 0) begin
         if (p) begin mode = 1; pos = 0; end
      end else if (mode == 1) begin
         if (pa) mode = 2;
         else begin
            pos++;
            if (pos == 32 * BEAT) begin
               pos = 0;
`ifndef NOTE_SEQ_LOOP_EN
               mode = 0;
               exp_done = 1;
`endif
            end
         end
      end else if (p) begin
         mode = 1;
      end
      #1;
      play = 0; pause = 0; stop = 0;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b0; play = 0; pause = 0; stop = 0;
      #12;
      check_all("reset");
      rst = 1'b1;

      // First beat: tone for 8 cycles, gap for 2, then beat 1 sounds.
      step(1, 0, 0, "tp1");
      check_eq("tp1.first", 32'(note_div), 32'd381679);
      for (int k = 2; k <= 11; k++) begin
         step(0, 0, 0, "tp1");
         check_eq("tp1.div", 32'(note_div), (k <= 8 || k == 11) ? 32'd381679 : 32'd0);
      end
      check_eq("tp1.idx", 32'(beat_idx), 32'd1);

      // Pause at beat 2 count 4, hold for 20 cycles, resume.
      step(0, 0, 1, "stop");
      step(1, 0, 0, "tp2");
      for (int k = 0; k < 24; k++) step(0, 0, 0, "tp2");
      step(0, 1, 0, "tp2");
      for (int k = 0; k < 20; k++) begin
         step(0, 0, 0, "hold");
         check_eq("hold.div", 32'(note_div), 32'd0);
         check_eq("hold.idx", 32'(beat_idx), 32'd2);
      end
      step(1, 0, 0, "resume");
      check_eq("resume.idx", 32'(beat_idx), 32'd2);
      check_eq("resume.div", 32'(note_div), 32'd255102);
      for (int k = 0; k < 4; k++) step(0, 0, 0, "resume");
      check_eq("resume.gap", 32'(note_div), 32'd0);

      // Simultaneous pulses: stop wins.
      step(1, 1, 1, "all3");
      check_eq("all3.idx",  32'(beat_idx), 32'd0);
      check_eq("all3.div",  32'(note_div), 32'd0);
      check_eq("all3.play", 32'(playing),  32'd0);

      // Whole song.
      step(1, 0, 0, "song");
      for (int n = 1; n <= 320; n++) begin
         step(0, 0, 0, "song");
`ifdef NOTE_SEQ_LOOP_EN
         check_eq("song.done", 32'(done), 32'd0);
`else
         check_eq("song.done", 32'(done), (n == 320) ? 32'd1 : 32'd0);
`endif
      end
`ifdef NOTE_SEQ_LOOP_EN
      check_eq("loop.idx",  32'(beat_idx), 32'd0);
      check_eq("loop.div",  32'(note_div), 32'd381679);
      check_eq("loop.play", 32'(playing),  32'd1);
`else
      check_eq("end.play", 32'(playing),  32'd0);
      check_eq("end.div",  32'(note_div), 32'd0);
`endif
      step(0, 0, 0, "after");
      check_eq("after.done", 32'(done), 32'd0);

      // Asynchronous reset mid-beat 7, between clock edges.
      step(0, 0, 1, "stop");
      step(1, 0, 0, "mid");
      for (int k = 0; k < 73; k++) step(0, 0, 0, "mid");
      check_eq("mid.idx", 32'(beat_idx), 32'd7);
      #2;
      rst = 1'b0;
      mode = 0; pos = 0; exp_done = 0;
      #1;
      check_all("arst");
      check_eq("arst.div", 32'(note_div), 32'd0);
      rst = 1'b1;

      // Random button pulses.
      for (int n = 0; n < 4000; n++)
         step($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
              $urandom_range(0, 127) == 0, "rnd");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
